// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer control path.
// Provides state encodings, state width and a counter-width helper.
package timer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SET   = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_rise_detect.sv
// Rising-edge detector for one debounced button level.
// Ports: clk_1Hz, reset (sync, active-high), btn (level in), rise (one-cycle pulse).
// History resets to 1 so a button held through reset release gives no edge.
module btn_rise_detect (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Control FSM for the MM:SS countdown timer: programming, run/pause, terminal detect, alarm.
// Ports: clk_1Hz, reset (sync, active-high), set_mode, start, sel_field, inc_btn,
//   sec_zero, min_zero in; sec_en, min_en (comb), forward, inc_sec, inc_min,
//   cnt_reset, alarm, state (registered) out.
// Optional macro TIMER_AUTOREPEAT_EN adds inc_btn hold-to-repeat in SET.
module countdown_sequencer
    import timer_pkg::*;
#(
    parameter int ALARM_CYCLES = 10
`ifdef TIMER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 3
`endif
) (
    input  logic               clk_1Hz,
    input  logic               reset,
    input  logic               set_mode,
    input  logic               start,
    input  logic               sel_field,
    input  logic               inc_btn,
    input  logic               sec_zero,
    input  logic               min_zero,
    output logic               sec_en,
    output logic               min_en,
    output logic               forward,
    output logic               inc_sec,
    output logic               inc_min,
    output logic               cnt_reset,
    output logic               alarm,
    output logic [STATE_W-1:0] state
);

    localparam int AW = cnt_w(ALARM_CYCLES);

    logic               start_rise;
    logic               inc_rise;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nxt;
    logic [AW-1:0]      alarm_cnt;
    logic               at_zero;
    logic               alarm_end;
    logic               in_set;
    logic               in_done;
    logic               rpt_fire;
    logic               strobe;

    btn_rise_detect u_start_det (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .btn     (start),
        .rise    (start_rise)
    );

    btn_rise_detect u_inc_det (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .btn     (inc_btn),
        .rise    (inc_rise)
    );

`ifdef TIMER_AUTOREPEAT_EN
    localparam int RW = cnt_w(REPEAT_DELAY + 1);

    // Saturates at REPEAT_DELAY; once there every held cycle fires.
    logic [RW-1:0] rpt_cnt;
    logic          rpt_sat;

    assign rpt_sat  = (rpt_cnt == RW'(REPEAT_DELAY));
    assign rpt_fire = inc_btn & rpt_sat;
`else
    assign rpt_fire = 1'b0;
`endif

    assign at_zero   = sec_zero & min_zero;
    assign alarm_end = (alarm_cnt == AW'(ALARM_CYCLES - 1));
    assign in_set    = (state_q == ST_SET);
    assign in_done   = (state_q == ST_DONE);

    // Strobe is judged on the current state so an edge seen while
    // leaving SET still produces its increment.
    assign strobe = in_set & (inc_rise | rpt_fire);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (set_mode) begin
                    state_nxt = ST_SET;
                end else if (start_rise && !at_zero) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_SET: begin
                if (!set_mode) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (at_zero) begin
                    state_nxt = ST_DONE;
                end else if (start_rise) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_rise) begin
                    state_nxt = ST_RUN;
                end else if (set_mode) begin
                    state_nxt = ST_SET;
                end
            end
            ST_DONE: begin
                if (start_rise || alarm_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Minutes borrow in the same cycle the seconds counter wraps.
    assign sec_en = (state_q == ST_RUN);
    assign min_en = sec_en & sec_zero & ~min_zero;
    assign state  = state_q;

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_reset <= 1'b1;
            forward   <= 1'b0;
            inc_sec   <= 1'b0;
            inc_min   <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
`ifdef TIMER_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            state_q   <= state_nxt;
            cnt_reset <= 1'b0;
            forward   <= (state_nxt == ST_SET);
            inc_sec   <= strobe & ~sel_field;
            inc_min   <= strobe & sel_field;
            alarm     <= (state_nxt == ST_DONE);
            if (in_done && state_nxt == ST_DONE) begin
                alarm_cnt <= alarm_cnt + 1'b1;
            end else begin
                alarm_cnt <= '0;
            end
`ifdef TIMER_AUTOREPEAT_EN
            if (in_set && inc_btn && state_nxt == ST_SET) begin
                if (!rpt_sat) begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end else begin
                rpt_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer.
// Expected output vectors are queued at drive time and checked after each clock edge.
module tb_countdown_sequencer;

    logic       clk_1Hz   = 1'b0;
    logic       reset     = 1'b1;
    logic       set_mode  = 1'b0;
    logic       start     = 1'b1;
    logic       sel_field = 1'b0;
    logic       inc_btn   = 1'b0;
    logic       sec_zero  = 1'b0;
    logic       min_zero  = 1'b0;
    logic       sec_en;
    logic       min_en;
    logic       forward;
    logic       inc_sec;
    logic       inc_min;
    logic       cnt_reset;
    logic       alarm;
    logic [2:0] state;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] sb[$];

`ifdef TIMER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    countdown_sequencer dut (
        .clk_1Hz   (clk_1Hz),
        .reset     (reset),
        .set_mode  (set_mode),
        .start     (start),
        .sel_field (sel_field),
        .inc_btn   (inc_btn),
        .sec_zero  (sec_zero),
        .min_zero  (min_zero),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .forward   (forward),
        .inc_sec   (inc_sec),
        .inc_min   (inc_min),
        .cnt_reset (cnt_reset),
        .alarm     (alarm),
        .state     (state)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    // Vector: {state, alarm, cnt_reset, forward, inc_sec, inc_min, sec_en, min_en}
    function automatic logic [9:0] ex(
        input logic [2:0] s,
        input logic al, input logic cr, input logic fw,
        input logic is, input logic im,
        input logic se, input logic me
    );
        return {s, al, cr, fw, is, im, se, me};
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] got,
                            input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [9:0] e);
        logic [9:0] got;
        logic [9:0] want;
        sb.push_back(e);
        @(posedge clk_1Hz);
        #1;
        got = {state, alarm, cnt_reset, forward, inc_sec, inc_min,
               sec_en, min_en};
        want = sb.pop_front();
        check_eq(tag, got, want);
    endtask

    logic [9:0] IDL;
    logic [9:0] SETV;
    logic [9:0] RUNV;

    initial begin
        IDL  = ex(3'd0, 0, 0, 0, 0, 0, 0, 0);
        SETV = ex(3'd1, 0, 0, 1, 0, 0, 0, 0);
        RUNV = ex(3'd2, 0, 0, 0, 0, 0, 1, 0);

        // Reset with start held: no run after release
        step("rst0", ex(3'd0, 0, 1, 0, 0, 0, 0, 0));
        step("rst1", ex(3'd0, 0, 1, 0, 0, 0, 0, 0));
        reset = 1'b0;
        step("rel_hold", IDL);
        step("hold_start", IDL);
        start = 1'b0;
        step("idle", IDL);

        // Programming minutes
        set_mode  = 1'b1;
        sel_field = 1'b1;
        step("enter_set", SETV);
        for (int i = 0; i < 3; i++) begin
            inc_btn = 1'b1;
            step("inc_min", ex(3'd1, 0, 0, 1, 0, 1, 0, 0));
            inc_btn = 1'b0;
            step("inc_gap", SETV);
        end
        set_mode = 1'b0;
        step("set_exit", IDL);

        // Run and borrow
        start = 1'b1;
        step("run_go", RUNV);
        start    = 1'b0;
        sec_zero = 1'b1;
        step("borrow", ex(3'd2, 0, 0, 0, 0, 0, 1, 1));
        sec_zero = 1'b0;
        step("no_borrow", RUNV);

        // Pause / resume
        start = 1'b1;
        step("pause", ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b0;
        step("pause_hold", ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b1;
        step("resume", RUNV);
        start = 1'b0;
        step("run", RUNV);

        // Terminal beats start; full alarm duration
        sec_zero = 1'b1;
        min_zero = 1'b1;
        start    = 1'b1;
        step("done_pri", ex(3'd4, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 9; i++) begin
            step("alarm_on", ex(3'd4, 1, 0, 0, 0, 0, 0, 0));
        end
        step("alarm_end", IDL);
        start = 1'b0;
        step("idle_zero", IDL);
        start = 1'b1;
        step("start_at_zero", IDL);

        // Early acknowledge
        sec_zero = 1'b0;
        min_zero = 1'b0;
        start    = 1'b0;
        step("idle2", IDL);
        start = 1'b1;
        step("run2", RUNV);
        start    = 1'b0;
        sec_zero = 1'b1;
        min_zero = 1'b1;
        step("done2", ex(3'd4, 1, 0, 0, 0, 0, 0, 0));
        start = 1'b1;
        step("ack", IDL);

        // PAUSE priorities and RUN ignoring set_mode
        sec_zero = 1'b0;
        min_zero = 1'b0;
        start    = 1'b0;
        step("idle3", IDL);
        start = 1'b1;
        step("run3", RUNV);
        start = 1'b0;
        step("run3_hold", RUNV);
        start = 1'b1;
        step("pause3", ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b0;
        step("pause3_hold", ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
        start    = 1'b1;
        set_mode = 1'b1;
        step("pause_pri", RUNV);
        start = 1'b0;
        step("run_ign_set", RUNV);
        start    = 1'b1;
        set_mode = 1'b0;
        step("pause4", ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
        start    = 1'b0;
        set_mode = 1'b1;
        step("pause_set", SETV);

        // Seconds hold: edge strobe, then repeat when enabled
        sel_field = 1'b0;
        inc_btn   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step("hold_inc", ex(3'd1, 0, 0, 1,
                                (k == 1) || (AR && k >= 4), 0, 0, 0));
        end
        inc_btn = 1'b0;
        step("hold_rel", SETV);
        set_mode = 1'b0;
        inc_btn  = 1'b1;
        step("exit_strobe", ex(3'd0, 0, 0, 0, 1, 0, 0, 0));
        inc_btn = 1'b0;
        step("exit_quiet", IDL);

        // Reset mid-RUN
        start = 1'b1;
        step("run4", RUNV);
        reset = 1'b1;
        step("rst_run", ex(3'd0, 0, 1, 0, 0, 0, 0, 0));
        reset = 1'b0;
        start = 1'b0;
        step("rst_rel", IDL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
